riscv_soft_axi_lite_master: RTL and testbench



---
 rtl/riscv_soft_axi_lite_master.sv | 221 ++++++++++++++++++++++
 tb/tb_riscv_soft_axi_lite_master.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_soft_axi_lite_master.sv
// AXI4-Lite master bridge for the riscv_soft tile memory port: one outstanding load/store at a time.
// Optional feature macro RISCV_SOFT_AXI_MASTER_ERR_EN: report BRESP/RRESP errors and reject misaligned H/W.
module riscv_soft_axi_lite_master #(
  parameter int unsigned XPR_LEN = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [2:0]           req_op_type,
  input  logic [XPR_LEN-1:0]   req_addr,
  input  logic [XPR_LEN-1:0]   req_data,
  output logic                 resp_valid,
  output logic [XPR_LEN-1:0]   resp_data,
  output logic                 resp_error,
  output logic [XPR_LEN-1:0]   M_AXI_AWADDR,
  output logic [2:0]           M_AXI_AWPROT,
  output logic                 M_AXI_AWVALID,
  input  logic                 M_AXI_AWREADY,
  output logic [XPR_LEN-1:0]   M_AXI_WDATA,
  output logic [XPR_LEN/8-1:0] M_AXI_WSTRB,
  output logic                 M_AXI_WVALID,
  input  logic                 M_AXI_WREADY,
  input  logic [1:0]           M_AXI_BRESP,
  input  logic                 M_AXI_BVALID,
  output logic                 M_AXI_BREADY,
  output logic [XPR_LEN-1:0]   M_AXI_ARADDR,
  output logic [2:0]           M_AXI_ARPROT,
  output logic                 M_AXI_ARVALID,
  input  logic                 M_AXI_ARREADY,
  input  logic [XPR_LEN-1:0]   M_AXI_RDATA,
  input  logic [1:0]           M_AXI_RRESP,
  input  logic                 M_AXI_RVALID,
  output logic                 M_AXI_RREADY
);

  localparam int unsigned STRB_W = XPR_LEN / 8;

  // Local mirror of the riscv_soft_constants.v memory encodings.
  localparam logic [1:0] MEM_LOAD    = 2'd1;
  localparam logic [1:0] MEM_STORE   = 2'd2;
  localparam logic [2:0] MEM_TYPE_B  = 3'd0;
  localparam logic [2:0] MEM_TYPE_H  = 3'd1;
  localparam logic [2:0] MEM_TYPE_W  = 3'd2;
  localparam logic [2:0] MEM_TYPE_BU = 3'd4;
  localparam logic [2:0] MEM_TYPE_HU = 3'd5;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t     state;
  logic [2:0] type_q;
  logic [1:0] lane_q;
  logic       aw_done;
  logic       w_done;
  logic       aw_hs;
  logic       w_hs;
  logic       ar_hs;
  logic       req_bypass;
  logic       unused_resp;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign aw_hs        = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs         = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs        = M_AXI_ARVALID && M_AXI_ARREADY;
  assign unused_resp  = ^{M_AXI_BRESP, M_AXI_RRESP};

  // Replicate the store operand across every lane it could land in.
  function automatic logic [XPR_LEN-1:0] store_lanes(input logic [2:0] t, input logic [XPR_LEN-1:0] d);
    case (t)
      MEM_TYPE_B, MEM_TYPE_BU: store_lanes = {(XPR_LEN/8){d[7:0]}};
      MEM_TYPE_H, MEM_TYPE_HU: store_lanes = {(XPR_LEN/16){d[15:0]}};
      default:                 store_lanes = d;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] store_strb(input logic [2:0] t, input logic [1:0] a);
    case (t)
      MEM_TYPE_B, MEM_TYPE_BU: store_strb = STRB_W'(4'b0001 << a);
      MEM_TYPE_H, MEM_TYPE_HU: store_strb = STRB_W'(4'b0011 << {a[1], 1'b0});
      default:                 store_strb = '1;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [XPR_LEN-1:0] load_extend(input logic [2:0] t, input logic [1:0] a,
                                                      input logic [XPR_LEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = 16'(d >> {a[1], 4'b0000});
    case (t)
      MEM_TYPE_B:  load_extend = {{(XPR_LEN-8){b[7]}}, b};
      MEM_TYPE_BU: load_extend = {{(XPR_LEN-8){1'b0}}, b};
      MEM_TYPE_H:  load_extend = {{(XPR_LEN-16){h[15]}}, h};
      MEM_TYPE_HU: load_extend = {{(XPR_LEN-16){1'b0}}, h};
      default:     load_extend = d;
    endcase
  endfunction

`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      MEM_TYPE_H, MEM_TYPE_HU: misaligned = a[0];
      MEM_TYPE_W:              misaligned = (a != 2'b00);
      default:                 misaligned = 1'b0;
    endcase
  endfunction

  assign req_bypass = ((req_op == MEM_LOAD) || (req_op == MEM_STORE)) &&
                      misaligned(req_op_type, req_addr[1:0]);
`else
  assign req_bypass = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_error    <= 1'b0;
      type_q        <= MEM_TYPE_W;
      lane_q        <= 2'b00;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            type_q     <= req_op_type;
            lane_q     <= req_addr[1:0];
            resp_data  <= '0;
            resp_error <= 1'b0;
            if (req_bypass) begin
              resp_error <= 1'b1;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else if (req_op == MEM_STORE) begin
              M_AXI_AWADDR  <= {req_addr[XPR_LEN-1:2], 2'b00};
              M_AXI_WDATA   <= store_lanes(req_op_type, req_data);
              M_AXI_WSTRB   <= store_strb(req_op_type, req_addr[1:0]);
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end else if (req_op == MEM_LOAD) begin
              M_AXI_ARADDR  <= {req_addr[XPR_LEN-1:2], 2'b00};
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end else begin
              resp_valid <= 1'b1;
              state      <= DONE;
            end
          end
        end
        // AW and W complete independently; leave once both have been taken.
        WR_REQ: begin
          if (aw_hs) M_AXI_AWVALID <= 1'b0;
          if (w_hs)  M_AXI_WVALID  <= 1'b0;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end else begin
            aw_done <= aw_done || aw_hs;
            w_done  <= w_done || w_hs;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            resp_valid   <= 1'b1;
`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
            resp_error   <= M_AXI_BRESP[1];
`endif
            state        <= DONE;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            resp_data    <= load_extend(type_q, lane_q, M_AXI_RDATA);
            resp_valid   <= 1'b1;
`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
            resp_error   <= M_AXI_RRESP[1];
`endif
            state        <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_soft_axi_lite_master.sv
// Scoreboard bench for riscv_soft_axi_lite_master: random and directed loads/stores against a
// behavioural AXI-Lite slave and a lane/extension reference model.
`timescale 1ns/1ps
module tb_riscv_soft_axi_lite_master;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [2:0] T_B  = 3'd0;
  localparam logic [2:0] T_H  = 3'd1;
  localparam logic [2:0] T_W  = 3'd2;
  localparam logic [2:0] T_BU = 3'd4;
  localparam logic [2:0] T_HU = 3'd5;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wexp_t;

  typedef struct {
    int          aw, w, ar, b, r;
    bit          early;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } cfg_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [2:0]  req_op_type = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  cfg_t  scfg;
  exp_t  eq[$];
  wexp_t wq[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_soft_axi_lite_master #(.XPR_LEN(32)) dut (
    .S_AXI_ACLK(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_op_type(req_op_type),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte/half selection by address arithmetic, then two's-complement extension.
  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (t == T_B || t == T_BU) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (t == T_B && v >= 32'd128) v = v - 32'd256;
    end else if (t == T_H || t == T_HU) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (t == T_H && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic wexp_t model_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    wexp_t w;
    w.addr = a - (a % 4);
    if (t == T_B) begin
      w.data = (d & 32'hFF) * 32'h01010101;
      w.strb = 4'(1 << (a % 4));
    end else if (t == T_H) begin
      w.data = (d & 32'hFFFF) * 32'h00010001;
      w.strb = 4'(3 << (2 * ((a / 2) % 2)));
    end else begin
      w.data = d;
      w.strb = 4'hF;
    end
    return w;
  endfunction

  function automatic cfg_t zcfg(input logic [31:0] rd, input logic [1:0] rr);
    cfg_t c;
    c.aw = 0; c.w = 0; c.ar = 0; c.b = 0; c.r = 0; c.early = 1'b0;
    c.rdata = rd; c.resp = rr;
    return c;
  endfunction

  // Wait for req_ready, push expectations, present the request for one accepted cycle.
  task automatic issue(input logic [1:0] op, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input cfg_t c, input int lat, input bit want_resp,
                       output int acc);
    exp_t e;
    bit   bypass;
    int   n;
    n = 0;
    acc = cyc;
    while (req_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got %b, expected 1 within 100 cycles", req_ready);
      return;
    end
    scfg = c;
    bypass = 1'b0;
`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
    if ((op == OP_LOAD || op == OP_STORE) &&
        ((((t == T_H) || (t == T_HU)) && (a % 2 != 0)) || ((t == T_W) && (a % 4 != 0))))
      bypass = 1'b1;
`endif
    e.data = '0; e.err = 1'b0; e.lat = lat;
    if (bypass) begin
      e.err = 1'b1;
    end else if (op == OP_STORE) begin
      wq.push_back(model_store(t, a, d));
`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
      e.err = c.resp[1];
`endif
    end else if (op == OP_LOAD) begin
      rq.push_back(a - (a % 4));
      e.data = model_load(t, a, c.rdata);
`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
      e.err = c.resp[1];
`endif
    end
    acc = cyc;
    e.acc = cyc;
    if (want_resp) eq.push_back(e);
    req_valid = 1'b1; req_op = op; req_op_type = t; req_addr = a; req_data = d;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom;
  endtask

  // Behavioural AXI-Lite slave with per-transaction ready/response delays.
  initial begin : slave
    bit aw_f, w_f, ar_f, b_f, r_f, got_aw, got_w, rd_pend, b_pend;
    int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic [31:0] cap_aw, cap_w, cap_ar;
    logic [3:0]  cap_s;
    wexp_t we;
    {aw_f, w_f, ar_f, b_f, r_f, got_aw, got_w, rd_pend, b_pend} = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
    cap_aw = '0; cap_w = '0; cap_ar = '0; cap_s = '0;
    forever begin
      tick();
      if (reset) begin
        {aw_f, w_f, ar_f, b_f, r_f, got_aw, got_w, rd_pend, b_pend} = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      end else begin
        if (aw_f) begin got_aw = 1'b1; aw_wait = 0; end
        if (w_f)  begin got_w = 1'b1; w_wait = 0; end
        if (ar_f) begin
          rd_pend = 1'b1; r_cnt = 0; ar_wait = 0;
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ar: got ARADDR 0x%08h, expected no read", cap_ar);
          end else chk("araddr", cap_ar, rq.pop_front());
        end
        if (b_f) bvalid = 1'b0;
        if (r_f) begin rvalid = 1'b0; rd_pend = 1'b0; end
        if (got_aw && got_w) begin
          got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1; b_cnt = 0;
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got AWADDR 0x%08h, expected no write", cap_aw);
          end else begin
            we = wq.pop_front();
            chk("awaddr", cap_aw, we.addr);
            chk("wdata", cap_w, we.data);
            chk("wstrb", 32'(cap_s), 32'(we.strb));
          end
        end
        if (b_pend) begin
          if (b_cnt >= scfg.b) begin bvalid = 1'b1; bresp = scfg.resp; b_pend = 1'b0; end
          else b_cnt++;
        end
        if (scfg.early && arvalid && !rvalid && !rd_pend) begin
          rvalid = 1'b1; rdata = scfg.rdata; rresp = scfg.resp;
        end
        if (rd_pend && !rvalid) begin
          if (r_cnt >= scfg.r) begin rvalid = 1'b1; rdata = scfg.rdata; rresp = scfg.resp; end
          else r_cnt++;
        end
        awready = awvalid && (aw_wait >= scfg.aw);
        wready  = wvalid && (w_wait >= scfg.w);
        arready = arvalid && (ar_wait >= scfg.ar);
        if (awvalid && !awready) aw_wait++;
        if (wvalid && !wready) w_wait++;
        if (arvalid && !arready) ar_wait++;
        aw_f = awvalid && awready;
        w_f  = wvalid && wready;
        ar_f = arvalid && arready;
        b_f  = bvalid && bready;
        r_f  = rvalid && rready;
        cap_aw = awaddr; cap_w = wdata; cap_s = wstrb; cap_ar = araddr;
      end
    end
  end

  // Response monitor: every resp_valid pulse consumes exactly one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_data 0x%08h, expected no response", resp_data);
        end else begin
          e = eq.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_error", 32'(resp_error), 32'(e.err));
          if (e.lat >= 0) chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a0, a1, n;
    cfg_t c;
    logic [2:0] st_types [3];
    logic [2:0] ld_types [5];
    st_types = '{T_B, T_H, T_W};
    ld_types = '{T_B, T_H, T_W, T_BU, T_HU};
    scfg = zcfg('0, 2'b00);
    repeat (3) tick();
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_error", 32'(resp_error), 0);
    reset = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 1);

    issue(OP_STORE, T_B, 32'h1003, 32'h000000A5, zcfg('0, 2'b00), 3, 1'b1, a0);
    issue(OP_LOAD, T_B, 32'h2002, 32'h0, zcfg(32'h00800000, 2'b00), 3, 1'b1, a0);
    issue(OP_LOAD, T_BU, 32'h2002, 32'h0, zcfg(32'h00800000, 2'b00), 3, 1'b1, a1);
    chk("b2b_gap", 32'(a1 - a0), 4);

    c = zcfg('0, 2'b00); c.w = 3; c.b = 1;
    issue(OP_STORE, T_W, 32'h1010, 32'h12345678, c, 7, 1'b1, a0);
    tick();
    chk("sw_awvalid_dropped", 32'(awvalid), 0);
    chk("sw_wvalid_held", 32'(wvalid), 1);

    c = zcfg(32'hDEADBEEF, 2'b00); c.ar = 2; c.early = 1'b1;
    issue(OP_LOAD, T_W, 32'h2000, 32'h0, c, 5, 1'b1, a0);
    issue(2'd0, T_W, 32'h44, 32'h0, zcfg('0, 2'b00), 1, 1'b1, a0);
    issue(OP_STORE, T_H, 32'h5002, 32'h0000BEEF, zcfg('0, 2'b00), 3, 1'b1, a0);
    issue(OP_LOAD, T_H, 32'h6000, 32'h0, zcfg(32'h1234F00D, 2'b00), 3, 1'b1, a0);

    // Reset held three cycles while the write is stuck in WR_REQ.
    c = zcfg('0, 2'b00); c.aw = 20; c.w = 20;
    issue(OP_STORE, T_W, 32'h40, 32'hCAFEF00D, c, -1, 1'b0, a0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("midrst_awvalid", 32'(awvalid), 0);
    chk("midrst_wvalid", 32'(wvalid), 0);
    reset = 1'b0;
    tick();
    chk("midrst_req_ready", 32'(req_ready), 1);
    wq.delete();

`ifdef RISCV_SOFT_AXI_MASTER_ERR_EN
    issue(OP_LOAD, T_W, 32'h3002, 32'h0, zcfg(32'h11111111, 2'b00), 1, 1'b1, a0);
    issue(OP_LOAD, T_W, 32'h3000, 32'h0, zcfg(32'h22222222, 2'b10), 3, 1'b1, a0);
    issue(OP_STORE, T_W, 32'h3004, 32'h5, zcfg('0, 2'b10), 3, 1'b1, a0);
`endif

    for (int i = 0; i < 150; i++) begin
      int k;
      logic [1:0] op;
      logic [2:0] t;
      k = $urandom_range(0, 9);
      if (k == 0) begin op = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3; t = T_W; end
      else if (k < 5) begin op = OP_STORE; t = st_types[$urandom_range(0, 2)]; end
      else begin op = OP_LOAD; t = ld_types[$urandom_range(0, 4)]; end
      c.aw = $urandom_range(0, 3); c.w = $urandom_range(0, 3); c.ar = $urandom_range(0, 3);
      c.b = $urandom_range(0, 3); c.r = $urandom_range(0, 3);
      c.early = ($urandom_range(0, 3) == 0);
      c.rdata = $urandom; c.resp = 2'($urandom_range(0, 3));
      issue(op, t, $urandom, $urandom, c, -1, 1'b1, a0);
      repeat ($urandom_range(0, 2)) tick();
    end

    n = 0;
    while (eq.size() != 0 && n < 100) begin tick(); n++; end
    repeat (5) tick();
    chk("pending_resp", 32'(eq.size()), 0);
    chk("pending_wr", 32'(wq.size()), 0);
    chk("pending_rd", 32'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
